// File: rtl/lstm_axi_pkg.sv
// rtl/lstm_axi_pkg.sv - shared types and constants for the LSTM AXI4-Lite master
package lstm_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RESPOND
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0] AXI_STRB_FULL    = 4'hF;

endpackage

// File: rtl/axi4_lite_lstm_master.sv
// rtl/axi4_lite_lstm_master.sv - single-outstanding AXI4-Lite initiator with error counter
module axi4_lite_lstm_master
    import lstm_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [31:0]          awaddr,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    output logic [31:0]          araddr,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    state_t state;

    assign awprot = AXI_PROT_DEFAULT;
    assign arprot = AXI_PROT_DEFAULT;
    assign wstrb  = AXI_STRB_FULL;

    function automatic logic [ERR_WIDTH-1:0] err_next(input logic [1:0] resp,
                                                      input logic [ERR_WIDTH-1:0] cnt);
        if (resp != RESP_OKAY && cnt != ERR_MAX)
            return cnt + 1'b1;
        return cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr + BASE_ADDR;
                            wdata   <= cmd_wdata;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= cmd_addr + BASE_ADDR;
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // A low valid here means that channel has already handshaken.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        err_count <= err_next(bresp, err_count);
                        state     <= RESPOND;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_valid <= 1'b1;
                        err_count <= err_next(rresp, err_count);
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_lstm_master.sv
// tb/tb_axi4_lite_lstm_master.sv - self-checking bench with behavioural AXI4-Lite responder
module tb_axi4_lite_lstm_master;
    import lstm_axi_pkg::*;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    logic        d2_cmd_ready, d2_rsp_valid, d2_rsp_write;
    logic [31:0] d2_rsp_rdata, d2_awaddr, d2_wdata, d2_araddr;
    logic [1:0]  d2_rsp_resp, d2_err;
    logic [2:0]  d2_awprot, d2_arprot;
    logic [3:0]  d2_wstrb;
    logic        d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready;

    axi4_lite_lstm_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Second instance sees identical inputs; it exercises BASE_ADDR and a narrow counter.
    axi4_lite_lstm_master #(.BASE_ADDR(32'h4000_0000), .ERR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(d2_rsp_write),
        .rsp_rdata(d2_rsp_rdata), .rsp_resp(d2_rsp_resp), .err_count(d2_err),
        .awaddr(d2_awaddr), .awprot(d2_awprot), .awvalid(d2_awvalid), .awready(awready),
        .wdata(d2_wdata), .wstrb(d2_wstrb), .wvalid(d2_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(d2_bready),
        .araddr(d2_araddr), .arprot(d2_arprot), .arvalid(d2_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(d2_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder configuration and observation
    int          a_wait = 0, w_wait = 0, d_wait = 0;
    logic [1:0]  cfg_resp = RESP_OKAY;
    logic [31:0] mem [256];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        have_aw, have_w, b_pend, r_pend;
    int          b_hs = 0, proto_err = 0;
    logic        skew_seen = 1'b0;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_araddr2;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_awprot, s_arprot;
    logic        p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_araddr2;
    logic [3:0]  p_wstrb;
    logic [2:0]  p_awprot, p_arprot;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (p_awv && awready) begin
                    have_aw = 1; s_awaddr = p_awaddr; s_awprot = p_awprot; aw_cnt = 0;
                    if (awvalid) proto_err++;
                end else if (p_awv && !awvalid) proto_err++;
                if (p_wv && wready) begin
                    have_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_cnt = 0;
                    if (wvalid) proto_err++;
                end else if (p_wv && !wvalid) proto_err++;
                if (p_arv && arready) begin
                    s_araddr = p_araddr; s_araddr2 = p_araddr2; s_arprot = p_arprot;
                    ar_cnt = 0; r_pend = 1; r_cnt = d_wait;
                    if (arvalid) proto_err++;
                end else if (p_arv && !arvalid) proto_err++;
                if (p_bready && bvalid) begin bvalid = 0; b_hs++; end
                if (p_rready && rvalid) rvalid = 0;
                if (wvalid == 1'b0 && awvalid == 1'b1) skew_seen = 1'b1;
                if (have_aw && have_w) begin
                    have_aw = 0; have_w = 0; b_pend = 1; b_cnt = d_wait;
                    if (cfg_resp == RESP_OKAY) mem[s_awaddr[9:2]] = s_wdata;
                end
                if (b_pend) begin
                    if (b_cnt == 0) begin bvalid = 1; bresp = cfg_resp; b_pend = 0; end
                    else b_cnt--;
                end
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        rvalid = 1; rdata = mem[s_araddr[9:2]]; rresp = cfg_resp; r_pend = 0;
                    end else r_cnt--;
                end
                awready = awvalid && (aw_cnt >= a_wait);
                if (awvalid && !awready) aw_cnt++;
                wready = wvalid && (w_cnt >= w_wait);
                if (wvalid && !wready) w_cnt++;
                arready = arvalid && (ar_cnt >= a_wait);
                if (arvalid && !arready) ar_cnt++;
            end
            p_awv = awvalid; p_wv = wvalid; p_arv = arvalid; p_bready = bready; p_rready = rready;
            p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_awprot = awprot;
            p_araddr = araddr; p_araddr2 = d2_araddr; p_arprot = arprot;
        end
    end

    // Reference model: error total and a memory that only OKAY writes update
    int          err_model = 0;
    logic [31:0] ref_mem [int];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                          output logic o_w, output logic [31:0] o_rd, output logic [1:0] o_resp,
                          output int lat, output int unstable);
        int n;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_accept_in_time", n < 100, 1);
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 500) begin @(negedge clk); lat++; end
        check("rsp_in_time", lat < 500, 1);
        o_w = rsp_write; o_rd = rsp_rdata; o_resp = rsp_resp;
        unstable = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_write !== o_w || rsp_rdata !== o_rd || rsp_resp !== o_resp || cmd_ready)
                unstable++;
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_valid_drops", rsp_valid, 0);
    endtask

    task automatic run_one(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int aw_, input int ww, input int dw, input logic [1:0] resp,
                           input logic [31:0] exp_rd, input int exp_lat, input int hold);
        logic o_w; logic [31:0] o_rd; logic [1:0] o_resp; int lat, unst, bh0;
        a_wait = aw_; w_wait = ww; d_wait = dw; cfg_resp = resp;
        bh0 = b_hs;
        do_txn(w, a, d, hold, o_w, o_rd, o_resp, lat, unst);
        if (resp != RESP_OKAY) err_model++;
        check($sformatf("%s rsp_write", tag), o_w, w);
        check($sformatf("%s rsp_rdata", tag), o_rd, exp_rd);
        check($sformatf("%s rsp_resp", tag), o_resp, resp);
        check($sformatf("%s d2_rsp_rdata", tag), d2_rsp_rdata, exp_rd);
        if (exp_lat > 0) check($sformatf("%s latency", tag), lat, exp_lat);
        if (hold > 0) check($sformatf("%s held_stable", tag), unst, 0);
        check($sformatf("%s err_count", tag), err_count, sat(err_model, 65535));
        check($sformatf("%s d2_err_count", tag), d2_err, sat(err_model, 3));
        if (w) begin
            check($sformatf("%s b_handshakes", tag), b_hs - bh0, 1);
            check($sformatf("%s awaddr", tag), s_awaddr, a);
            check($sformatf("%s wdata", tag), s_wdata, d);
            check($sformatf("%s wstrb", tag), s_wstrb, 4'hF);
            check($sformatf("%s awprot", tag), s_awprot, 3'b000);
        end else begin
            check($sformatf("%s b_handshakes", tag), b_hs - bh0, 0);
            check($sformatf("%s araddr", tag), s_araddr, a);
            check($sformatf("%s d2_araddr", tag), s_araddr2, a + 32'h4000_0000);
            check($sformatf("%s arprot", tag), s_arprot, 3'b000);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        int          a_w, w_w, d_w;
        logic [1:0]  resp;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] wts [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, RESP_OKAY,   32'h0,        3};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        0, 0, 0, RESP_OKAY,   32'hDEADBEEF, 3};
        vecs[2]  = '{1'b0, 32'h20, 32'h0,        0, 0, 0, RESP_OKAY,   32'h12345678, 3};
        vecs[3]  = '{1'b1, 32'h30, 32'hCAFEF00D, 3, 0, 5, RESP_OKAY,   32'h0,        11};
        vecs[4]  = '{1'b0, 32'h30, 32'h0,        2, 0, 1, RESP_OKAY,   32'hCAFEF00D, 6};
        vecs[5]  = '{1'b1, 32'h34, 32'h11111111, 0, 0, 0, RESP_SLVERR, 32'h0,        3};
        vecs[6]  = '{1'b0, 32'h38, 32'h0,        0, 0, 0, RESP_DECERR, 32'h0,        3};
        vecs[7]  = '{1'b1, 32'h3C, 32'h22222222, 1, 2, 0, RESP_EXOKAY, 32'h0,        5};
        vecs[8]  = '{1'b0, 32'h34, 32'h0,        0, 0, 0, RESP_SLVERR, 32'h0,        3};
        vecs[9]  = '{1'b1, 32'h40, 32'h33333333, 0, 0, 0, RESP_DECERR, 32'h0,        3};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,        0, 0, 0, RESP_EXOKAY, 32'h0,        3};
        mem[8] = 32'h12345678;

        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
        check("reset readies", {bready, rready}, 2'b00);
        check("reset rsp", {rsp_write, rsp_rdata, rsp_resp}, 35'h0);
        check("reset addrs", {awaddr, araddr}, 64'h0);
        check("reset wdata", wdata, 0);
        check("reset err_count", err_count, 0);
        check("fixed prot/strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
        rst = 0;
        @(negedge clk);

        skew_seen = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].a_w,
                    vecs[i].w_w, vecs[i].d_w, vecs[i].resp, vecs[i].exp_rd, vecs[i].exp_lat, 0);
            if (i == 3) check("skew wvalid dropped while awvalid high", skew_seen, 1);
            if (i == 6) check("err_count after two errors", err_count, 2);
        end
        check("err_count after six errors", err_count, 6);
        check("narrow err_count saturates", d2_err, 2'b11);
        check("protocol violations", proto_err, 0);

        ref_mem[32'h10] = 32'hDEADBEEF;
        run_one("backpressure", 1'b0, 32'h10, 32'h0, 0, 0, 0, RESP_OKAY, 32'hDEADBEEF, 3, 10);

        for (int i = 0; i < 30; i++) begin
            logic w; logic [31:0] a, d, exp_rd; logic [1:0] resp;
            w = 1'($urandom_range(0, 1));
            a = 32'h200 + 32'($urandom_range(0, 15) * 4);
            d = $urandom;
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
            exp_rd = (!w && ref_mem.exists(a)) ? ref_mem[a] : 32'h0;
            run_one($sformatf("rand%0d", i), w, a, d, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), resp, exp_rd, -1, $urandom_range(0, 2));
            if (w && resp == RESP_OKAY) ref_mem[a] = d;
        end
        check("protocol violations after random", proto_err, 0);

        a_wait = 20; w_wait = 0; d_wait = 0; cfg_resp = RESP_OKAY;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h55AA55AA;
        while (!cmd_ready) @(negedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("awvalid pending before reset", awvalid, 1);
        rst = 1;
        @(negedge clk);
        check("abort valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
        check("abort readies", {bready, rready, cmd_ready}, 3'b000);
        check("abort err_count", err_count, 0);
        check("abort d2 err_count", d2_err, 0);
        rst = 0;
        err_model = 0;
        @(negedge clk);
        run_one("after_reset", 1'b1, 32'h50, 32'h600DF00D, 0, 0, 0, RESP_OKAY, 32'h0, 3, 0);

        for (int i = 0; i < 16; i++) begin
            wts[i] = $urandom;
            run_one($sformatf("e2e_wr%0d", i), 1'b1, 32'h100 + 32'(i * 4), wts[i], $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), RESP_OKAY, 32'h0, -1, 0);
        end
        for (int i = 0; i < 16; i++)
            run_one($sformatf("e2e_rd%0d", i), 1'b0, 32'h100 + 32'(i * 4), 32'h0, $urandom_range(0, 2),
                    0, $urandom_range(0, 2), RESP_OKAY, wts[i], -1, 0);
        check("e2e err_count", err_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
